// File: rtl/flank_detector_pkg.sv
// Shared types for the flank detector: FSM state encoding, edge selection and
// the Moore output decode.
package flank_detector_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'b00,
    RISE = 2'b01,
    ONE  = 2'b10,
    FALL = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10
  } edge_mode_t;

  localparam int unsigned MaxSyncStages = 3;

  // Pulse when the FSM sits in a transition state selected by the edge mode.
  function automatic logic pulse_for(input state_t st, input edge_mode_t mode);
    logic pulse;
    pulse = 1'b0;
    case (mode)
      EDGE_RISE: pulse = (st == RISE);
      EDGE_FALL: pulse = (st == FALL);
      EDGE_BOTH: pulse = (st == RISE) || (st == FALL);
      default:   pulse = 1'b0;
    endcase
    return pulse;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage level synchronizer with synchronous active-low clear; Stages == 0
// passes the input straight through.
module sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (Stages == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_chain
    logic [Stages-1:0] sync_q;
    logic [Stages-1:0] sync_d;

    // Shift toward the MSB; the MSB is the fully synchronized level.
    always_comb begin
      sync_d = Stages'({sync_q, d_i});
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= sync_d;
      end
    end

    assign q_o = sync_q[Stages-1];
  end

endmodule

// File: rtl/flank_detector_fsm.sv
// Moore edge detector: synchronizes a level, tracks it in a four-state FSM and
// emits a registered one-cycle pulse for each selected transition.
module flank_detector_fsm
  import flank_detector_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_mode_t  EDGE_MODE   = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_signal,
  output logic o_out
);

  logic   s;
  state_t state_q;
  state_t state_d;
  logic   out_q;
  logic   out_d;

  sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (i_signal),
    .q_o   (s)
  );

  always_comb begin
    state_d = ZERO;
    case (state_q)
      ZERO:    state_d = s ? RISE : ZERO;
      RISE:    state_d = s ? ONE  : FALL;
      ONE:     state_d = s ? ONE  : FALL;
      FALL:    state_d = s ? RISE : ZERO;
      default: state_d = ZERO;
    endcase
  end

  // Output flop tracks the decode of the next state, so it always equals the
  // decode of the state register without any path from i_signal to o_out.
  always_comb begin
    out_d = pulse_for(state_d, EDGE_MODE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ZERO;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign o_out = out_q;

endmodule

// File: tb/tb_flank_detector_fsm.sv
// Bench for flank_detector_fsm: four configurations share one stimulus and are
// checked every cycle against a delay-line edge model plus directed timings.
module tb_flank_detector_fsm;
  import flank_detector_pkg::*;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic i_signal = 1'b0;
  logic o_rise, o_both0, o_fall, o_rise1;
  logic [3:0] obs;

  int total = 0;
  int bad   = 0;

  // Reference: raw samples in a delay line; a pulse is a change of the
  // delayed level, and reset clears the line and the previous level.
  logic [3:0] hist    = '0;
  logic       p0      = 1'b0;
  logic       p1      = 1'b0;
  logic       p2      = 1'b0;
  logic [3:0] exp_vec = '0;  // {rise/2, both/0, fall/2, rise/1}

  always #10 clk = ~clk;

  flank_detector_fsm #(.SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE)) u_rise (
    .clk(clk), .rst(rst), .i_signal(i_signal), .o_out(o_rise));
  flank_detector_fsm #(.SYNC_STAGES(0), .EDGE_MODE(EDGE_BOTH)) u_both0 (
    .clk(clk), .rst(rst), .i_signal(i_signal), .o_out(o_both0));
  flank_detector_fsm #(.SYNC_STAGES(2), .EDGE_MODE(EDGE_FALL)) u_fall (
    .clk(clk), .rst(rst), .i_signal(i_signal), .o_out(o_fall));
  flank_detector_fsm #(.SYNC_STAGES(1), .EDGE_MODE(EDGE_RISE)) u_rise1 (
    .clk(clk), .rst(rst), .i_signal(i_signal), .o_out(o_rise1));

  assign obs = {o_rise, o_both0, o_fall, o_rise1};

  always @(posedge clk) begin : model
    logic [3:0] h;
    if (!rst) begin
      hist    <= '0;
      p0      <= 1'b0;
      p1      <= 1'b0;
      p2      <= 1'b0;
      exp_vec <= '0;
    end else begin
      h = {hist[2:0], i_signal};
      hist    <= h;
      exp_vec <= {h[2] & ~p2, h[0] ^ p0, ~h[2] & p2, h[1] & ~p1};
      p0      <= h[0];
      p1      <= h[1];
      p2      <= h[2];
    end
  end

  task automatic wait_to(input longint t);
    if (t > longint'($time)) #(t - longint'($time));
  endtask

  task automatic test_reset();
    wait_to(15);
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_edge1 got=%b want=0000", obs);
    end
    wait_to(25);
    total++;
    if (obs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_edge2 got=%b want=0000", obs);
    end
    wait_to(35);
    rst = 1'b1;
  endtask

  task automatic test_clean_rise();
    int     n_r = 0;
    longint t_r = 0;
    int     n_b = 0;
    longint tb0 = 0;
    longint tb1 = 0;
    wait_to(41);
    i_signal = 1'b1;
    fork
      begin
        wait_to(241);
        i_signal = 1'b0;
      end
      repeat (14) begin
        @(negedge clk);
        total++;
        if (obs !== exp_vec) begin
          bad++;
          $display("FAIL clean_model t=%0t got=%b want=%b", $time, obs, exp_vec);
        end
        if (o_rise) begin
          n_r++;
          t_r = longint'($time);
        end
        if (o_both0) begin
          if (n_b == 0) tb0 = longint'($time);
          else tb1 = longint'($time);
          n_b++;
        end
      end
    join
    total++;
    if (n_r != 1) begin
      bad++;
      $display("FAIL clean_count got=%0d want=1", n_r);
    end
    total++;
    if (t_r != 100) begin
      bad++;
      $display("FAIL clean_time got=%0d want=100", t_r);
    end
    total++;
    if (n_b != 2 || (tb1 - tb0) != 200) begin
      bad++;
      $display("FAIL both_long got=%0d pulses gap %0d want=2 pulses gap 200", n_b, tb1 - tb0);
    end
  endtask

  task automatic test_toggles();
    int n_r = 0;
    wait_to(401);
    fork
      begin
        i_signal = 1'b1;
        wait_to(416); i_signal = 1'b0;
        wait_to(421); i_signal = 1'b1;
        wait_to(436); i_signal = 1'b0;
        wait_to(466); i_signal = 1'b1;
        wait_to(481); i_signal = 1'b0;
      end
      repeat (10) begin
        @(negedge clk);
        total++;
        if (obs !== exp_vec) begin
          bad++;
          $display("FAIL toggle_model t=%0t got=%b want=%b", $time, obs, exp_vec);
        end
        if (o_rise) n_r++;
      end
    join
    total++;
    if (n_r != 2) begin
      bad++;
      $display("FAIL toggle_count got=%0d want=2", n_r);
    end
  endtask

  task automatic test_glitch();
    int     n_r = 0;
    longint t_r = 0;
    wait_to(601);
    fork
      begin
        wait_to(612); i_signal = 1'b1;
        wait_to(615); i_signal = 1'b0;
        wait_to(648); i_signal = 1'b1;
        wait_to(651); i_signal = 1'b0;
      end
      repeat (8) begin
        @(negedge clk);
        total++;
        if (obs !== exp_vec) begin
          bad++;
          $display("FAIL glitch_model t=%0t got=%b want=%b", $time, obs, exp_vec);
        end
        if (o_rise) begin
          n_r++;
          t_r = longint'($time);
        end
      end
    join
    total++;
    if (n_r != 1 || t_r != 700) begin
      bad++;
      $display("FAIL glitch_pulses got=%0d at %0d want=1 at 700", n_r, t_r);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int     n_r = 0;
    longint t_r = 0;
    wait_to(801);
    i_signal = 1'b1;
    fork
      begin
        wait_to(845); rst = 1'b0;
        wait_to(855); rst = 1'b1;
      end
      repeat (10) begin
        @(negedge clk);
        total++;
        if (obs !== exp_vec) begin
          bad++;
          $display("FAIL rstmid_model t=%0t got=%b want=%b", $time, obs, exp_vec);
        end
        if ($time == 860) begin
          total++;
          if (o_rise !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_kill got=%b want=0", o_rise);
          end
        end
        if (o_rise) begin
          n_r++;
          t_r = longint'($time);
        end
      end
    join
    total++;
    if (n_r != 1 || t_r != 920) begin
      bad++;
      $display("FAIL rstmid_repulse got=%0d at %0d want=1 at 920", n_r, t_r);
    end
    wait_to(1001);
    i_signal = 1'b0;
  endtask

  task automatic test_fall();
    int     n_f = 0;
    longint t_f = 0;
    wait_to(1101);
    fork
      begin
        wait_to(1141); i_signal = 1'b1;
        wait_to(1301); i_signal = 1'b0;
      end
      repeat (15) begin
        @(negedge clk);
        total++;
        if (obs !== exp_vec) begin
          bad++;
          $display("FAIL fall_model t=%0t got=%b want=%b", $time, obs, exp_vec);
        end
        if (o_fall) begin
          n_f++;
          t_f = longint'($time);
        end
      end
    join
    total++;
    if (n_f != 1 || t_f != 1360) begin
      bad++;
      $display("FAIL fall_pulse got=%0d at %0d want=1 at 1360", n_f, t_f);
    end
  endtask

  task automatic test_both_single();
    int     n_b = 0;
    longint t0  = 0;
    longint t1  = 0;
    wait_to(1405);
    i_signal = 1'b1;
    wait_to(1415);
    i_signal = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL both1_model t=%0t got=%b want=%b", $time, obs, exp_vec);
      end
      if (o_both0) begin
        if (n_b == 0) t0 = longint'($time);
        else t1 = longint'($time);
        n_b++;
      end
    end
    total++;
    if (n_b != 2 || t0 != 1420 || t1 != 1440) begin
      bad++;
      $display("FAIL both1_pulses got=%0d at %0d,%0d want=2 at 1420,1440", n_b, t0, t1);
    end
  endtask

  task automatic test_random();
    int unsigned off;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      total++;
      if (obs !== exp_vec) begin
        bad++;
        $display("FAIL random_model t=%0t got=%b want=%b", $time, obs, exp_vec);
      end
      off = $urandom_range(1, 18);
      if (off >= 10) off++;
      #(off);
      if ($urandom_range(0, 2) == 0) i_signal = ~i_signal;
      rst = ($urandom_range(0, 40) != 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_toggles();
    test_glitch();
    test_reset_mid_pulse();
    test_fall();
    test_both_single();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
